// File: rtl/cpu_control.sv
// Multi-cycle control FSM for an RV32I core: fetch/decode/execute/mem/writeback
// sequencing, instruction latch, and datapath strobes decoded from state and instr.
module cpu_control #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] mem_rdata,
   input  logic             mem_ready,
   input  logic             EQ,
   input  logic             LT,
   input  logic             LTU,
   output logic             mem_req,
   output logic             mem_we,
   output logic             addr_sel,
   output logic [WIDTH-1:0] instr,
   output logic             isALUreg,
   output logic             isBranch,
   output logic             pc_we,
   output logic [1:0]       pc_sel,
   output logic             rf_we,
   output logic [1:0]       wb_sel,
   output logic             halted,
   output logic [2:0]       state
);

   typedef enum logic [2:0] {
      S_FETCH   = 3'd0,
      S_DECODE  = 3'd1,
      S_EXECUTE = 3'd2,
      S_MEM     = 3'd3,
      S_WB      = 3'd4,
      S_HALT    = 3'd5
   } state_t;

   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] instr_q;
   logic [6:0]       opcode;
   logic [2:0]       funct3;
   logic             rd_nz;
   logic             taken;
   logic             branch_ok;

   assign opcode = instr_q[6:0];
   assign funct3 = instr_q[14:12];
   assign rd_nz  = (instr_q[11:7] != 5'd0);
   assign instr  = instr_q;
   assign state  = state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         instr_q <= 32'h0000_0013;
      end else begin
         state_q <= state_d;
         if (state_q == S_FETCH && mem_ready)
            instr_q <= mem_rdata;
      end
   end

   // funct3 010/011 have no branch meaning and are routed to HALT
   always_comb begin
      taken     = 1'b0;
      branch_ok = 1'b1;
      case (funct3)
         3'b000:  taken = EQ;
         3'b001:  taken = !EQ;
         3'b100:  taken = LT;
         3'b101:  taken = !LT;
         3'b110:  taken = LTU;
         3'b111:  taken = !LTU;
         default: branch_ok = 1'b0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      addr_sel = 1'b0;
      isALUreg = 1'b0;
      isBranch = 1'b0;
      pc_we    = 1'b0;
      pc_sel   = 2'd0;
      rf_we    = 1'b0;
      wb_sel   = 2'd0;
      halted   = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready)
               state_d = S_DECODE;
         end
         S_DECODE: state_d = S_EXECUTE;
         S_EXECUTE: begin
            state_d = S_HALT;
            if (instr_q[1:0] == 2'b11) begin
               case (opcode)
                  OP_OP, OP_IMM: begin
                     isALUreg = (opcode == OP_OP);
                     rf_we    = rd_nz;
                     pc_we    = 1'b1;
                     state_d  = S_FETCH;
                  end
                  OP_LUI, OP_AUIPC: begin
                     rf_we   = rd_nz;
                     wb_sel  = 2'd3;
                     pc_we   = 1'b1;
                     state_d = S_FETCH;
                  end
                  OP_BRANCH: begin
                     if (branch_ok) begin
                        isBranch = 1'b1;
                        pc_we    = 1'b1;
                        pc_sel   = taken ? 2'd1 : 2'd0;
                        state_d  = S_FETCH;
                     end
                  end
                  OP_JAL: begin
                     rf_we   = rd_nz;
                     wb_sel  = 2'd2;
                     pc_we   = 1'b1;
                     pc_sel  = 2'd2;
                     state_d = S_FETCH;
                  end
                  OP_JALR: begin
                     if (funct3 == 3'b000) begin
                        rf_we   = rd_nz;
                        wb_sel  = 2'd2;
                        pc_we   = 1'b1;
                        pc_sel  = 2'd3;
                        state_d = S_FETCH;
                     end
                  end
                  OP_LOAD, OP_STORE: state_d = S_MEM;
                  default: state_d = S_HALT;
               endcase
            end
         end
         S_MEM: begin
            // only LOAD or STORE can reach this state, so opcode picks the direction
            mem_req  = 1'b1;
            addr_sel = 1'b1;
            mem_we   = (opcode == OP_STORE);
            if (mem_ready) begin
               if (opcode == OP_STORE) begin
                  pc_we   = 1'b1;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end
         end
         S_WB: begin
            rf_we   = rd_nz;
            wb_sel  = 2'd1;
            pc_we   = 1'b1;
            state_d = S_FETCH;
         end
         S_HALT: begin
            halted  = 1'b1;
            state_d = S_HALT;
         end
         default: state_d = S_HALT;
      endcase
   end

endmodule

// File: tb/tb_cpu_control.sv
// Bench for cpu_control: a per-instruction trace model fills stimulus and expected
// queues; each test task drains them cycle by cycle and compares all outputs.
module tb_cpu_control;

   localparam int W = 47;
   localparam logic [31:0] NOP  = 32'h0000_0013;
   localparam logic [2:0]  S_F  = 3'd0;
   localparam logic [2:0]  S_D  = 3'd1;
   localparam logic [2:0]  S_E  = 3'd2;
   localparam logic [2:0]  S_M  = 3'd3;
   localparam logic [2:0]  S_W  = 3'd4;
   localparam logic [2:0]  S_H  = 3'd5;

   typedef struct packed {
      logic [31:0] rdata;
      logic        ready;
      logic        eq;
      logic        lt;
      logic        ltu;
   } stim_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [31:0] mem_rdata = 32'd0;
   logic        mem_ready = 1'b0;
   logic        EQ = 1'b0, LT = 1'b0, LTU = 1'b0;
   logic        mem_req, mem_we, addr_sel, isALUreg, isBranch, pc_we, rf_we, halted;
   logic [31:0] instr;
   logic [1:0]  pc_sel, wb_sel;
   logic [2:0]  state;

   stim_t        stim_q[$];
   logic [W-1:0] exp_q[$];
   logic [31:0]  cur_instr = NOP;
   int           pass_cnt = 0;
   int           total_cnt = 0;

   cpu_control #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .EQ(EQ), .LT(LT), .LTU(LTU), .mem_req(mem_req), .mem_we(mem_we),
      .addr_sel(addr_sel), .instr(instr), .isALUreg(isALUreg), .isBranch(isBranch),
      .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we), .wb_sel(wb_sel),
      .halted(halted), .state(state)
   );

   always #5 clk = ~clk;

   // pc_sel / wb_sel only carry meaning alongside their strobe
   function automatic logic [W-1:0] mk(logic [31:0] ins, logic [2:0] st, logic hl, logic rq,
                                       logic we, logic as, logic pw, logic [1:0] ps,
                                       logic rw, logic [1:0] ws, logic ia, logic ib);
      return {ins, st, hl, rq, we, as, pw, (pw ? ps : 2'd0), rw, (rw ? ws : 2'd0), ia, ib};
   endfunction

   function automatic logic [W-1:0] obs();
      return mk(instr, state, halted, mem_req, mem_we, addr_sel, pc_we, pc_sel,
                rf_we, wb_sel, isALUreg, isBranch);
   endfunction

   task automatic push_s(input logic [31:0] d, input logic r, input logic e,
                         input logic l, input logic lu);
      stim_q.push_back({d, r, e, l, lu});
   endtask

   task automatic drive_cycle(input stim_t s);
      @(posedge clk);
      #1;
      mem_rdata = s.rdata;
      mem_ready = s.ready;
      EQ        = s.eq;
      LT        = s.lt;
      LTU       = s.ltu;
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      mem_ready = 1'b0;
      rst_n     = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n     = 1'b1;
      cur_instr = NOP;
   endtask

   // Expected trace of one instruction: fw fetch waits, mw memory waits, hc halt cycles
   task automatic model_push(input logic [31:0] ins, input int fw, input int mw,
                             input logic e, input logic l, input logic lu, input int hc);
      logic [6:0] op;
      logic [2:0] f3;
      logic       rdnz, tk, st, pw, rw, ia, ib;
      logic [1:0] ps, ws;
      int         nxt;
      op = ins[6:0]; f3 = ins[14:12]; rdnz = (ins[11:7] != 5'd0);
      pw = 1'b0; rw = 1'b0; ia = 1'b0; ib = 1'b0; ps = 2'd0; ws = 2'd0; nxt = 2;
      for (int i = 0; i < fw; i++) begin
         push_s($urandom, 1'b0, 1'b0, 1'b0, 1'b0);
         exp_q.push_back(mk(cur_instr, S_F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0));
      end
      push_s(ins, 1'b1, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(mk(cur_instr, S_F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0));
      cur_instr = ins;
      push_s($urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
      exp_q.push_back(mk(ins, S_D, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0));
      tk = f3[2] ? (f3[1] ? lu : l) : e;
      if (f3[0]) tk = !tk;
      if (ins[1:0] == 2'b11) begin
         case (op)
            7'b0110011: begin ia = 1'b1; rw = rdnz; pw = 1'b1; nxt = 0; end
            7'b0010011: begin rw = rdnz; pw = 1'b1; nxt = 0; end
            7'b0110111, 7'b0010111: begin rw = rdnz; ws = 2'd3; pw = 1'b1; nxt = 0; end
            7'b1100011: if (f3 != 3'b010 && f3 != 3'b011) begin
               ib = 1'b1; pw = 1'b1; ps = tk ? 2'd1 : 2'd0; nxt = 0;
            end
            7'b1101111: begin rw = rdnz; ws = 2'd2; pw = 1'b1; ps = 2'd2; nxt = 0; end
            7'b1100111: if (f3 == 3'b000) begin
               rw = rdnz; ws = 2'd2; pw = 1'b1; ps = 2'd3; nxt = 0;
            end
            7'b0000011, 7'b0100011: nxt = 1;
            default: nxt = 2;
         endcase
      end
      push_s($urandom, 1'($urandom_range(0, 1)), e, l, lu);
      exp_q.push_back(mk(ins, S_E, 1'b0, 1'b0, 1'b0, 1'b0, pw, ps, rw, ws, ia, ib));
      if (nxt == 1) begin
         st = (op == 7'b0100011);
         for (int i = 0; i < mw; i++) begin
            push_s($urandom, 1'b0, 1'b0, 1'b0, 1'b0);
            exp_q.push_back(mk(ins, S_M, 1'b0, 1'b1, st, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0));
         end
         push_s($urandom, 1'b1, 1'b0, 1'b0, 1'b0);
         exp_q.push_back(mk(ins, S_M, 1'b0, 1'b1, st, 1'b1, st, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0));
         if (!st) begin
            push_s($urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
            exp_q.push_back(mk(ins, S_W, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, rdnz, 2'd1, 1'b0, 1'b0));
         end
      end else if (nxt == 2) begin
         for (int i = 0; i < hc; i++) begin
            push_s($urandom, 1'($urandom_range(0, 1)), 1'($urandom), 1'($urandom), 1'($urandom));
            exp_q.push_back(mk(ins, S_H, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0));
         end
      end
   endtask

   task automatic test_reset();
      logic [W-1:0] exp_v;
      #2 rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         mem_ready = 1'($urandom_range(0, 1));
         mem_rdata = $urandom;
         @(negedge clk);
         exp_v = mk(NOP, S_F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
         total_cnt++;
         if (obs() !== exp_v) $display("FAIL reset: got %h want %h", obs(), exp_v);
         else pass_cnt++;
      end
      mem_ready = 1'b0;
      rst_n     = 1'b1;
      cur_instr = NOP;
   endtask

   task automatic test_alu();
      logic [W-1:0] exp_v;
      model_push(32'h002081B3, 0, 0, 1'b0, 1'b0, 1'b0, 0);
      model_push(32'h00708293, 2, 0, 1'b0, 1'b0, 1'b0, 0);
      model_push(32'h12345337, 1, 0, 1'b0, 1'b0, 1'b0, 0);
      model_push(32'h00001397, 0, 0, 1'b0, 1'b0, 1'b0, 0);
      model_push(32'h00208033, 3, 0, 1'b0, 1'b0, 1'b0, 0);
      while (exp_q.size() > 0) begin
         drive_cycle(stim_q.pop_front());
         exp_v = exp_q.pop_front();
         total_cnt++;
         if (obs() !== exp_v) $display("FAIL alu: got %h want %h", obs(), exp_v);
         else pass_cnt++;
      end
   endtask

   task automatic test_branch();
      logic [W-1:0] exp_v;
      logic [2:0]   f3s[6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
      logic [31:0]  ins;
      model_push(32'h00208463, 0, 0, 1'b1, 1'b0, 1'b0, 0);
      model_push(32'h00208463, 0, 0, 1'b0, 1'b0, 1'b0, 0);
      for (int i = 0; i < 12; i++) begin
         ins = 32'h00208463 | {17'd0, f3s[i % 6], 12'd0};
         model_push(ins, $urandom_range(0, 1), 0, 1'($urandom), 1'($urandom), 1'($urandom), 0);
      end
      while (exp_q.size() > 0) begin
         drive_cycle(stim_q.pop_front());
         exp_v = exp_q.pop_front();
         total_cnt++;
         if (obs() !== exp_v) $display("FAIL branch: got %h want %h", obs(), exp_v);
         else pass_cnt++;
      end
   endtask

   task automatic test_jump();
      logic [W-1:0] exp_v;
      model_push(32'h008000EF, 0, 0, 1'b0, 1'b0, 1'b0, 0);
      model_push(32'h000100E7, 1, 0, 1'b0, 1'b0, 1'b0, 0);
      model_push(32'h0000006F, 0, 0, 1'b0, 1'b0, 1'b0, 0);
      while (exp_q.size() > 0) begin
         drive_cycle(stim_q.pop_front());
         exp_v = exp_q.pop_front();
         total_cnt++;
         if (obs() !== exp_v) $display("FAIL jump: got %h want %h", obs(), exp_v);
         else pass_cnt++;
      end
   endtask

   task automatic test_load_store();
      logic [W-1:0] exp_v;
      model_push(32'h0000A183, 0, 2, 1'b0, 1'b0, 1'b0, 0);
      model_push(32'h0020A023, 0, 0, 1'b0, 1'b0, 1'b0, 0);
      model_push(32'h0020A023, 2, 3, 1'b0, 1'b0, 1'b0, 0);
      model_push(32'h0000A003, 1, 0, 1'b0, 1'b0, 1'b0, 0);
      while (exp_q.size() > 0) begin
         drive_cycle(stim_q.pop_front());
         exp_v = exp_q.pop_front();
         total_cnt++;
         if (obs() !== exp_v) $display("FAIL load_store: got %h want %h", obs(), exp_v);
         else pass_cnt++;
      end
   endtask

   task automatic test_halt();
      logic [W-1:0] exp_v;
      logic [31:0]  bad[5] = '{32'h00000073, 32'hFFFFFFFF, 32'h0020A463, 32'h00001067, 32'h00000010};
      for (int k = 0; k < 5; k++) begin
         model_push(bad[k], 0, 0, 1'b0, 1'b0, 1'b0, (k == 0) ? 100 : 4);
         while (exp_q.size() > 0) begin
            drive_cycle(stim_q.pop_front());
            exp_v = exp_q.pop_front();
            total_cnt++;
            if (obs() !== exp_v) $display("FAIL halt[%0d]: got %h want %h", k, obs(), exp_v);
            else pass_cnt++;
         end
         do_reset();
         exp_v = mk(NOP, S_F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
         total_cnt++;
         if (obs() !== exp_v) $display("FAIL halt_exit[%0d]: got %h want %h", k, obs(), exp_v);
         else pass_cnt++;
      end
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] exp_v;
      logic [W-1:0] rst_v;
      int           keep[2] = '{4, 2};
      rst_v = mk(NOP, S_F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
         // k=0 stops inside a load's memory wait, k=1 inside a fetch wait
         if (k == 0) model_push(32'h0000A183, 0, 5, 1'b0, 1'b0, 1'b0, 0);
         else model_push(32'h00708293, 4, 0, 1'b0, 1'b0, 1'b0, 0);
         for (int i = 0; i < keep[k]; i++) begin
            drive_cycle(stim_q.pop_front());
            exp_v = exp_q.pop_front();
            total_cnt++;
            if (obs() !== exp_v) $display("FAIL reset_mid_pre[%0d]: got %h want %h", k, obs(), exp_v);
            else pass_cnt++;
         end
         exp_q.delete();
         stim_q.delete();
         #2 rst_n = 1'b0;
         #1;
         total_cnt++;
         if (obs() !== rst_v) $display("FAIL reset_mid_async[%0d]: got %h want %h", k, obs(), rst_v);
         else pass_cnt++;
         mem_ready = 1'b1;
         @(posedge clk);
         #1;
         total_cnt++;
         if (obs() !== rst_v) $display("FAIL reset_mid_hold[%0d]: got %h want %h", k, obs(), rst_v);
         else pass_cnt++;
         @(negedge clk);
         mem_ready = 1'b0;
         rst_n     = 1'b1;
         cur_instr = NOP;
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] exp_v;
      logic [31:0]  pool[10] = '{32'h002081B3, 32'h00708293, 32'h12345337, 32'h00001397,
                                 32'h00208033, 32'h008000EF, 32'h000100E7, 32'h0000A183,
                                 32'h0020A023, 32'h00208463};
      logic [2:0]   f3s[6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
      logic [31:0]  ins;
      for (int i = 0; i < 25; i++) begin
         ins = pool[$urandom_range(0, 9)];
         if (ins[6:0] == 7'b1100011) ins = 32'h00208063 | {17'd0, f3s[$urandom_range(0, 5)], 12'd0};
         model_push(ins, $urandom_range(0, 2), $urandom_range(0, 2),
                    1'($urandom), 1'($urandom), 1'($urandom), 0);
      end
      while (exp_q.size() > 0) begin
         drive_cycle(stim_q.pop_front());
         exp_v = exp_q.pop_front();
         total_cnt++;
         if (obs() !== exp_v) $display("FAIL back_to_back: got %h want %h", obs(), exp_v);
         else pass_cnt++;
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_branch();
      test_jump();
      test_load_store();
      test_halt();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #300000;
      total_cnt++;
      $display("FAIL watchdog: time limit reached, run did not complete");
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/cpu_control.md
CPU_CONTROL -- requirements
Module: cpu_control

Interface
REQ-001 Parameter: WIDTH, 32, datapath width; only 32 is supported.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 mem_rdata  in  32  memory read data (instruction or load data).
REQ-005 mem_ready  in  1  memory completes the current request this cycle.
REQ-006 EQ, LT, LTU  in  1 each  ALU compare flags for rs1 vs rs2.
REQ-007 mem_req  out  1  memory request; held high until mem_ready.
REQ-008 mem_we  out  1  store request; valid only with mem_req.
REQ-009 addr_sel  out  1  0 = address is PC, 1 = address is ALU result.
REQ-010 instr  out  32  latched instruction register.
REQ-011 isALUreg, isBranch  out  1 each  ALU operand-select controls; funct3/funct7 are taken from instr.
REQ-012 pc_we  out  1  PC update strobe.
REQ-013 pc_sel  out  2  next PC source: 0 = PC+4, 1 = PC+Bimm, 2 = PC+Jimm, 3 = (rs1+Iimm)&~1.
REQ-014 rf_we  out  1  register-file write strobe; suppressed when rd = x0.
REQ-015 wb_sel  out  2  writeback source: 0 = aluOut, 1 = load data, 2 = PC+4, 3 = Uimm / PC+Uimm.
REQ-016 halted  out  1  controller is in HALT.
REQ-017 state  out  3  current state encoding, for debug.

Function
REQ-018 States: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, HALT=5. Encodings 6 and 7 go to HALT.
REQ-019 All control outputs are decoded combinationally from state and instr only; there is no combinational path from mem_rdata to any control output.
REQ-020 FETCH:
- mem_req=1, mem_we=0, addr_sel=0.
- On mem_ready: instr <= mem_rdata, then go to DECODE.
- Otherwise remain in FETCH.
REQ-021 DECODE: one cycle, all strobes 0 (register-file read slot), then go to EXECUTE.
REQ-022 EXECUTE decodes opcode instr[6:0]:
- OP (0110011): isALUreg=1.
- OP-IMM (0010011), LUI, AUIPC: isALUreg=0.
- These four assert rf_we and pc_we with pc_sel=0, then go to FETCH.
REQ-023 Branch (1100011) in EXECUTE:
- isBranch=1, pc_we=1.
- taken by funct3: 000 EQ; 001 !EQ; 100 LT; 101 !LT; 110 LTU; 111 !LTU.
- pc_sel=1 if taken, else 0.
- funct3 010 or 011 is illegal.
REQ-024 JAL (1101111): rf_we=1, wb_sel=2, pc_we=1, pc_sel=2.
REQ-025 JALR (1100111), funct3 must be 000: rf_we=1, wb_sel=2, pc_we=1, pc_sel=3.
REQ-026 LOAD (0000011) or STORE (0100011) in EXECUTE: no strobes, go to MEM.
REQ-027 MEM:
- mem_req=1, addr_sel=1, mem_we=1 for STORE only.
- Wait for mem_ready.
- LOAD: go to WB.
- STORE: assert pc_we (pc_sel=0) in the mem_ready cycle, then go to FETCH.
REQ-028 WB: rf_we=1, wb_sel=1, pc_we=1, pc_sel=0, then go to FETCH.
REQ-029 SYSTEM (1110011), any unlisted opcode, or instr[1:0] != 11: go to HALT with no strobes.
REQ-030 HALT: all strobes 0, halted=1; leave only by reset.
REQ-031 Strobes are one-cycle pulses: pc_we and rf_we each assert exactly once per retired instruction.
REQ-032 mem_ready outside FETCH or MEM is ignored.
REQ-033 mem_ready in the first cycle of a request (zero wait states) is legal; the same transition rules apply.
REQ-034 Minimum cycles per instruction: ALU/branch/jump 3, store 4, load 5; each memory wait cycle adds 1.
REQ-035 While mem_ready is low: mem_req, mem_we and addr_sel are held stable, and instr is unchanged.

Reset
REQ-036 rst_n low asynchronously forces state=FETCH and instr=32'h00000013 (NOP).
REQ-037 During reset all strobes are 0 and halted=0; mem_req=1 follows from the FETCH state.
REQ-038 Reset asserted mid-transaction (MEM or FETCH wait) abandons the transaction with no pc_we or rf_we pulse.
REQ-039 After rst_n rises, the first fetch begins in the next cycle.

Verification
REQ-040 ADD x3,x1,x2 (0x002081B3), mem_ready=1 always -> states 0,1,2; one rf_we and one pc_we (pc_sel=0) in cycle 3; isALUreg=1.
REQ-041 BEQ (0x00208463) with EQ=1 -> pc_sel=1, pc_we=1; rerun with EQ=0 -> pc_sel=0; rf_we stays 0 in both runs.
REQ-042 LW (0x0000A183) with 2 wait cycles in MEM:
- addr_sel=1 and mem_we=0 held for 3 cycles.
- WB then has rf_we=1, wb_sel=1.
- Total 7 cycles.
REQ-043 SW (0x0020A023) -> mem_we=1 in MEM; pc_we in the mem_ready cycle; rf_we never asserts.
REQ-044 ECALL (0x00000073) or 0xFFFFFFFF -> HALT; halted=1 persists for 100 cycles with no strobes; rst_n pulse returns state to FETCH.
REQ-045 rst_n pulsed low during MEM wait -> state=FETCH immediately; no pc_we or rf_we pulse; instr=0x00000013.
